// File: rtl/burst_mem_ctrl.sv
// Burst memory controller: a small register memory written and read in INCR or WRAP bursts,
// with command validation, write-beat stalls, abort on loss of start, and async clear.
module burst_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic              io_wr,
  input  logic              io_rd,
  input  logic [ADDR_W-1:0] io_address,
  input  logic [LEN_W-1:0]  io_length,
  input  logic              io_wrap,
  input  logic [DATA_W-1:0] io_wdata,
  input  logic              io_wvalid,
  output logic              io_wready,
  output logic              io_cmd_ready,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_rvalid,
  output logic              io_rlast,
  output logic              io_busy,
  output logic              io_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WBURST, RBURST} state_t;

  state_t            state, next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len_reg;
  logic              wrap_reg;
  logic [DATA_W-1:0] rdata;
  logic              rvalid, rlast, err;

  logic cmd_ready, wready, err_set;
  logic accept_wr, accept_rd, beat_wr, beat_rd;
  logic wrap_len_ok, cmd_legal, cmd_bad;

  // WRAP bursts stay inside an aligned window of length words, so the length must be a power of two.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [LEN_W-1:0]  len,
                                                  input logic              wrp);
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] inc;
    mask = ADDR_W'(len - LEN_W'(1));
    inc  = a + ADDR_W'(1);
    if (wrp) next_addr = (a & ~mask) | (inc & mask);
    else     next_addr = inc;
  endfunction

  assign wrap_len_ok = (io_length == LEN_W'(2)) || (io_length == LEN_W'(4)) ||
                       (io_length == LEN_W'(8));
  assign cmd_legal   = (io_wr ^ io_rd) && (io_length != '0) && (!io_wrap || wrap_len_ok);
  assign cmd_bad     = (io_wr && io_rd) ||
                       ((io_wr || io_rd) && ((io_length == '0) || (io_wrap && !wrap_len_ok)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    wready     = 1'b0;
    err_set    = 1'b0;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    beat_wr    = 1'b0;
    beat_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (io_start) begin
          if (cmd_legal) begin
            cmd_ready = 1'b1;
            if (io_wr) begin
              wready    = 1'b1;
              accept_wr = 1'b1;
              if (!(io_wvalid && (io_length == LEN_W'(1)))) next_state = WBURST;
            end else begin
              accept_rd  = 1'b1;
              next_state = RBURST;
            end
          end else if (cmd_bad) begin
            err_set = 1'b1;
          end
        end
      end
      WBURST: begin
        if (!io_start) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else begin
          wready = 1'b1;
          if (io_wvalid) begin
            beat_wr = 1'b1;
            if (count == LEN_W'(1)) next_state = IDLE;
          end
        end
      end
      RBURST: begin
        if (!io_start) begin
          err_set    = 1'b1;
          next_state = IDLE;
        end else if (count == '0) begin
          next_state = IDLE;
        end else begin
          beat_rd = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The first read beat is fetched on the accept edge so rvalid rises the very next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      addr     <= '0;
      count    <= '0;
      len_reg  <= '0;
      wrap_reg <= 1'b0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      err      <= 1'b0;
    end else begin
      err    <= err_set;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      if (accept_wr) begin
        len_reg  <= io_length;
        wrap_reg <= io_wrap;
        if (io_wvalid) begin
          mem[io_address] <= io_wdata;
          addr            <= next_addr(io_address, io_length, io_wrap);
          count           <= io_length - LEN_W'(1);
        end else begin
          addr  <= io_address;
          count <= io_length;
        end
      end else if (beat_wr) begin
        mem[addr] <= io_wdata;
        addr      <= next_addr(addr, len_reg, wrap_reg);
        count     <= count - LEN_W'(1);
      end else if (accept_rd) begin
        len_reg  <= io_length;
        wrap_reg <= io_wrap;
        rdata    <= mem[io_address];
        rvalid   <= 1'b1;
        rlast    <= (io_length == LEN_W'(1));
        addr     <= next_addr(io_address, io_length, io_wrap);
        count    <= io_length - LEN_W'(1);
      end else if (beat_rd) begin
        rdata  <= mem[addr];
        rvalid <= 1'b1;
        rlast  <= (count == LEN_W'(1));
        addr   <= next_addr(addr, len_reg, wrap_reg);
        count  <= count - LEN_W'(1);
      end
    end
  end

  assign io_cmd_ready = cmd_ready & ~reset;
  assign io_wready    = wready & ~reset;
  assign io_rdata     = rdata;
  assign io_rvalid    = rvalid;
  assign io_rlast     = rlast;
  assign io_busy      = (state != IDLE);
  assign io_err       = err;

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Self-checking bench for burst_mem_ctrl: command table, directed burst sequences and
// randomized bursts scored against an address-list memory model.
module tb_burst_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start, io_wr, io_rd, io_wrap, io_wvalid;
  logic [3:0]  io_address, io_length;
  logic [31:0] io_wdata;
  logic        io_wready, io_cmd_ready, io_rvalid, io_rlast, io_busy, io_err;
  logic [31:0] io_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] model_mem [16];
  logic [31:0] wbuf [16];
  logic [31:0] exp_buf [16];

  typedef struct {
    logic       start, wr, rd;
    logic [3:0] length;
    logic       wrap;
    logic       exp_ready, exp_err;
  } vec_t;

  vec_t vecs [14];

  burst_mem_ctrl dut (
    .clock(clock), .reset(reset), .io_start(io_start), .io_wr(io_wr), .io_rd(io_rd),
    .io_address(io_address), .io_length(io_length), .io_wrap(io_wrap),
    .io_wdata(io_wdata), .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_cmd_ready(io_cmd_ready), .io_rdata(io_rdata), .io_rvalid(io_rvalid),
    .io_rlast(io_rlast), .io_busy(io_busy), .io_err(io_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word address of beat i, from the burst rules rather than any incremental formula.
  function automatic int burst_addr(int a, int len, bit wrp, int i);
    int base;
    if (!wrp) return (a + i) % 16;
    base = a - (a % len);
    return base + ((a - base + i) % len);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic r, input int a,
                               input int len, input logic wp, input logic [31:0] d,
                               input logic v);
    io_start   = s;
    io_wr      = w;
    io_rd      = r;
    io_address = a[3:0];
    io_length  = len[3:0];
    io_wrap    = wp;
    io_wdata   = d;
    io_wvalid  = v;
  endtask

  task automatic drive_idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic drive_junk(input logic [31:0] d, input logic v);
    applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15), $urandom_range(1, 15), 1'($urandom_range(0, 1)), d, v);
  endtask

  task automatic do_write(input int a, input int len, input bit wrp, input bit first,
                          input int gap_at, input int gap_n);
    int i;
    i = 0;
    applyStimulus(1, 1, 0, a, len, wrp, first ? wbuf[0] : 32'h0, first);
    #1;
    checkOutput("wr_cmd_ready", io_cmd_ready, 1);
    checkOutput("wr_wready_accept", io_wready, 1);
    if (first) begin
      model_mem[burst_addr(a, len, wrp, 0)] = wbuf[0];
      i = 1;
    end
    @(negedge clock);
    while (i < len) begin
      if (i == gap_at && gap_at > 0) begin
        for (int g = 0; g < gap_n; g++) begin
          drive_junk(32'hBAD0_0000, 0);
          #1;
          checkOutput("wr_stall_busy", io_busy, 1);
          checkOutput("wr_stall_wready", io_wready, 1);
          checkOutput("wr_stall_cmd_ready", io_cmd_ready, 0);
          @(negedge clock);
        end
      end
      drive_junk(wbuf[i], 1);
      #1;
      checkOutput("wr_busy", io_busy, 1);
      checkOutput("wr_wready", io_wready, 1);
      model_mem[burst_addr(a, len, wrp, i)] = wbuf[i];
      @(negedge clock);
      i++;
    end
    drive_idle();
    #1;
    checkOutput("wr_done_busy", io_busy, 0);
    checkOutput("wr_done_err", io_err, 0);
  endtask

  task automatic do_read(input int a, input int len, input bit wrp, input bit use_exp,
                         input int abort_after);
    bit          aborted;
    logic [31:0] expv;
    logic [31:0] last;
    aborted = 0;
    last    = 32'h0;
    applyStimulus(1, 0, 1, a, len, wrp, 32'h0, 0);
    #1;
    checkOutput("rd_cmd_ready", io_cmd_ready, 1);
    checkOutput("rd_wready", io_wready, 0);
    @(negedge clock);
    for (int i = 0; i < len; i++) begin
      expv = use_exp ? exp_buf[i] : model_mem[burst_addr(a, len, wrp, i)];
      last = expv;
      checkOutput("rd_rvalid", io_rvalid, 1);
      checkOutput("rd_rdata", io_rdata, expv);
      checkOutput("rd_rlast", io_rlast, (i == len - 1) ? 1 : 0);
      checkOutput("rd_busy", io_busy, 1);
      if (abort_after > 0 && i == abort_after - 1) begin
        drive_idle();
        aborted = 1;
      end else begin
        drive_junk(32'h0, 0);
        #1;
        checkOutput("rd_busy_cmd_ready", io_cmd_ready, 0);
      end
      @(negedge clock);
      if (aborted) break;
    end
    checkOutput("rd_end_rvalid", io_rvalid, 0);
    checkOutput("rd_end_rlast", io_rlast, 0);
    checkOutput("rd_end_busy", io_busy, 0);
    checkOutput("rd_end_err", io_err, aborted ? 1 : 0);
    if (!aborted) checkOutput("rd_hold_rdata", io_rdata, last);
    drive_idle();
    if (aborted) begin
      @(negedge clock);
      checkOutput("rd_abort_err_single", io_err, 0);
    end
  endtask

  initial begin
    int          a, len, op;
    bit          wrp;
    logic [31:0] d;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'd4,  1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'd3,  1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'd2,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'd8,  1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    reset = 1'b1;
    drive_idle();
    @(negedge clock);
    checkOutput("reset_rdata", io_rdata, 0);
    checkOutput("reset_rvalid", io_rvalid, 0);
    checkOutput("reset_busy", io_busy, 0);
    checkOutput("reset_err", io_err, 0);
    reset = 1'b0;

    // Command legality: accepted rows drop start before the edge so no burst begins.
    for (int r = 0; r < 14; r++) begin
      applyStimulus(vecs[r].start, vecs[r].wr, vecs[r].rd, 3, vecs[r].length, vecs[r].wrap,
                    32'hDEAD, 1);
      #1;
      checkOutput($sformatf("vec%0d_cmd_ready", r), io_cmd_ready, vecs[r].exp_ready);
      checkOutput($sformatf("vec%0d_wready", r), io_wready, vecs[r].exp_ready & vecs[r].wr);
      if (vecs[r].exp_ready) drive_idle();
      @(negedge clock);
      checkOutput($sformatf("vec%0d_err", r), io_err, vecs[r].exp_err);
      checkOutput($sformatf("vec%0d_busy", r), io_busy, 0);
      drive_idle();
      @(negedge clock);
      checkOutput($sformatf("vec%0d_err_clear", r), io_err, 0);
    end
    do_read(3, 1, 0, 0, 0);

    // INCR write A..D at 6 then read back.
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
    do_write(6, 4, 0, 1, 0, 0);
    exp_buf[0] = 32'hA; exp_buf[1] = 32'hB; exp_buf[2] = 32'hC; exp_buf[3] = 32'hD;
    do_read(6, 4, 0, 1, 0);

    // Address wrap at the top of memory, then a WRAP read visiting 6,7,4,5.
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    do_write(15, 2, 0, 1, 0, 0);
    exp_buf[0] = 32'h1; exp_buf[1] = 32'h2;
    do_read(15, 2, 0, 1, 0);
    exp_buf[0] = 32'h2;
    do_read(0, 1, 0, 1, 0);
    wbuf[0] = 32'h40; wbuf[1] = 32'h50; wbuf[2] = 32'h60; wbuf[3] = 32'h70;
    do_write(4, 4, 0, 1, 0, 0);
    exp_buf[0] = 32'h60; exp_buf[1] = 32'h70; exp_buf[2] = 32'h40; exp_buf[3] = 32'h50;
    do_read(6, 4, 1, 1, 0);

    // Three-cycle wvalid gap between beats 2 and 3.
    wbuf[0] = 32'h111; wbuf[1] = 32'h222; wbuf[2] = 32'h333; wbuf[3] = 32'h444;
    do_write(9, 4, 0, 1, 2, 3);
    exp_buf[0] = 32'h111; exp_buf[1] = 32'h222; exp_buf[2] = 32'h333; exp_buf[3] = 32'h444;
    do_read(9, 4, 0, 1, 0);

    for (int it = 0; it < 40; it++) begin
      op  = $urandom_range(0, 1);
      a   = $urandom_range(0, 15);
      wrp = 1'($urandom_range(0, 1));
      len = wrp ? (2 << $urandom_range(0, 2)) : $urandom_range(1, 15);
      if (op == 0) begin
        for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
        do_write(a, len, wrp, 1'($urandom_range(0, 1)),
                 (len > 1) ? $urandom_range(0, len - 1) : 0, $urandom_range(0, 2));
      end else begin
        do_read(a, len, wrp, 0, 0);
      end
    end
    do_read(0, 15, 0, 0, 0);
    do_read(15, 1, 0, 0, 0);

    // Abort a read after three beats.
    do_read(0, 8, 0, 0, 3);

    // Reset in the middle of a write burst.
    for (int k = 0; k < 16; k++) wbuf[k] = $urandom | 32'h1;
    applyStimulus(1, 1, 0, 2, 4, 0, wbuf[0], 1);
    @(negedge clock);
    applyStimulus(1, 0, 0, 0, 0, 0, wbuf[1], 1);
    @(negedge clock);
    applyStimulus(1, 1, 0, 5, 4, 0, wbuf[2], 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_rdata", io_rdata, 0);
    checkOutput("rst_mid_rvalid", io_rvalid, 0);
    checkOutput("rst_mid_rlast", io_rlast, 0);
    checkOutput("rst_mid_busy", io_busy, 0);
    checkOutput("rst_mid_err", io_err, 0);
    checkOutput("rst_mid_cmd_ready", io_cmd_ready, 0);
    checkOutput("rst_mid_wready", io_wready, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) model_mem[k] = 32'h0;
    do_read(0, 15, 0, 0, 0);
    do_read(15, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/burst_mem_ctrl.md
BURST_MEM_CTRL -- requirements
Module: burst_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, word address width; memory depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter LEN_W, default 4, burst length field width.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port io_start  in  1  enable; must stay high for a burst to proceed.
REQ-007 SHALL have port io_wr  in  1  write command request.
REQ-008 SHALL have port io_rd  in  1  read command request.
REQ-009 SHALL have port io_address  in  ADDR_W  burst start word address.
REQ-010 SHALL have port io_length  in  LEN_W  burst beat count (1..2**LEN_W-1).
REQ-011 SHALL have port io_wrap  in  1  0 = INCR burst, 1 = WRAP burst.
REQ-012 SHALL have port io_wdata  in  DATA_W  write beat data.
REQ-013 SHALL have port io_wvalid  in  1  write beat valid.
REQ-014 SHALL have port io_wready  out  1  write beat accepted when wvalid & wready.
REQ-015 SHALL have port io_cmd_ready  out  1  command accepted this cycle.
REQ-016 SHALL have port io_rdata  out  DATA_W  read beat data.
REQ-017 SHALL have port io_rvalid  out  1  rdata valid.
REQ-018 SHALL have port io_rlast  out  1  final read beat.
REQ-019 SHALL have port io_busy  out  1  high in WBURST or RBURST.
REQ-020 SHALL have port io_err  out  1  one-cycle error pulse.

Function
REQ-021 SHALL implement states IDLE, WBURST, RBURST; internal DEPTH x DATA_W register memory, address register, beat counter.
REQ-022 SHALL accept a command (io_cmd_ready=1, combinational) in IDLE when start=1, exactly one of wr/rd =1, length!=0, and (wrap=0 or length in {2,4,8}).
REQ-023 SHALL pulse io_err for one cycle, no state change, when in IDLE with start=1 and: wr&rd both 1, or (wr|rd) with length=0, or wrap=1 with illegal length.
REQ-024 SHALL assert io_wready in WBURST, and in IDLE during the write-accept cycle (first beat may accompany the command).
REQ-025 SHALL write mem[addr] <= wdata on each wvalid&wready edge, then advance addr and decrement remaining count; wvalid=0 stalls without advancing.
REQ-026 SHALL return WBURST -> IDLE on the edge accepting the last beat; a length-1 write with wvalid at accept stays in IDLE.
REQ-027 SHALL, on read accept at edge N, drive rvalid=1 for cycles N+1..N+length, one beat per cycle from registered memory read, no backpressure; rlast=1 only on beat length; RBURST -> IDLE after last beat.
REQ-028 SHALL compute next address INCR as (addr+1) mod DEPTH.
REQ-029 SHALL compute next address WRAP as (addr & ~(length-1)) | ((addr+1) & (length-1)).
REQ-030 SHALL, if start drops in WBURST/RBURST, abort: pulse io_err, deassert rvalid/rlast next cycle, return to IDLE; completed beats remain written.
REQ-031 SHALL ignore wr/rd/address/length/wrap while busy; io_cmd_ready=0 while busy.
REQ-032 SHALL hold io_rdata at last read value when rvalid=0.

Reset
REQ-033 SHALL, on reset=1 (asynchronous, any state incl. mid-burst), force IDLE, clear memory, address, counter to 0, and drive rdata=0, rvalid=0, rlast=0, busy=0, err=0, cmd_ready=0 while reset is high.
REQ-034 SHALL resume command acceptance on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL verify INCR write/read: write addr 6, length 4, beats A,B,C,D (A with command) -> read addr 6 length 4 returns A,B,C,D on 4 consecutive cycles, rlast on D.
REQ-036 SHALL verify wrap-around: INCR write addr 15 length 2 data 1,2 -> mem[15]=1, mem[0]=2; WRAP read addr 6 length 4 -> addresses 6,7,4,5.
REQ-037 SHALL verify wvalid stall: 3-cycle gap between beats 2 and 3 -> addr holds, busy stays 1, data correct.
REQ-038 SHALL verify errors: wr&rd=1, length=0, wrap with length 3 -> io_err single pulse, state IDLE, memory unchanged.
REQ-039 SHALL verify abort and reset: start low mid-read -> err pulse, rvalid low next cycle; reset mid-write -> all outputs 0 immediately, memory reads 0.
